// File: rtl/seq_detect_fsm.sv
// Serial sequence detector: KMP-style fallback FSM with Mealy look-ahead flag,
// registered match pulse, saturating hit counter and aux capture on match.
module seq_detect_fsm #(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1101,
  parameter bit             OVERLAP = 1'b1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    din,
  input  logic                    aux,
  input  logic                    clr,
  output logic                    match_next,
  output logic                    match,
  output logic [$clog2(LEN)-1:0]  state,
  output logic [CNT_W-1:0]        hit_count,
  output logic                    aux_q
);

  localparam int unsigned SW = $clog2(LEN);
  typedef logic [SW-1:0] st_t;

  if (LEN < 2 || LEN > 16) begin : g_len_chk
    $error("seq_detect_fsm: LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_chk
    $error("seq_detect_fsm: CNT_W must be in 1..32");
  end

  // Entry {k,b}: longest prefix of PATTERN (shorter than LEN) that is a suffix
  // of "first k pattern bits followed by b"; accepting entries drop to 0 when
  // overlap is disabled.
  function automatic logic [2*LEN*SW-1:0] build_next();
    logic [2*LEN*SW-1:0] tbl;
    int unsigned best;
    int unsigned lim;
    int unsigned idx;
    logic        ok;
    logic        bb;
    logic        sbit;
    tbl = '0;
    for (int unsigned k = 0; k < LEN; k++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        bb   = b[0];
        best = 0;
        lim  = (k + 1 < LEN) ? k + 1 : LEN - 1;
        for (int unsigned j = 1; j <= lim; j++) begin
          ok = 1'b1;
          for (int unsigned i = 0; i < j; i++) begin
            idx  = k + 1 - j + i;
            sbit = (idx == k) ? bb : PATTERN[LEN-1-idx];
            if (sbit != PATTERN[LEN-1-i]) ok = 1'b0;
          end
          if (ok) best = j;
        end
        if (k == LEN - 1 && bb == PATTERN[0] && !OVERLAP) best = 0;
        tbl[(2*k+b)*SW +: SW] = best[SW-1:0];
      end
    end
    return tbl;
  endfunction

  localparam logic [2*LEN*SW-1:0] NEXT_TBL = build_next();

  st_t              state_q, state_d;
  logic             match_q;
  logic             aux_cap_q;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             accept;
  int unsigned      sel;

  always_comb begin
    accept  = en && (state_q == st_t'(LEN - 1)) && (din == PATTERN[0]);
    sel     = 32'({state_q, din}) * SW;
    state_d = state_q;
    if (en) state_d = NEXT_TBL[sel +: SW];
    hit_d = hit_q;
    if (clr)
      hit_d = '0;
    else if (accept && hit_q != '1)
      hit_d = hit_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      match_q   <= 1'b0;
      aux_cap_q <= 1'b0;
      hit_q     <= '0;
    end else begin
      state_q <= state_d;
      match_q <= accept;
      if (accept) aux_cap_q <= aux;
      hit_q <= hit_d;
    end
  end

  assign match_next = accept;
  assign match      = match_q;
  assign state      = state_q;
  assign hit_count  = hit_q;
  assign aux_q      = aux_cap_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: four configurations share one stimulus stream and are
// checked against a bit-history reference model plus hand-computed vectors.
module tb_seq_detect_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, en = 1'b0, din = 1'b0, aux = 1'b0, clr = 1'b0;

  logic       mnx [4];
  logic       mt  [4];
  logic [1:0] st  [4];
  logic [7:0] hc  [4];
  logic       aq  [4];
  logic [1:0] hc2;

  // u0: 1101 overlap, u1: 1101 no overlap, u2: 1101 2-bit counter, u3: 1111 overlap
  seq_detect_fsm #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .reset(rst), .en(en), .din(din), .aux(aux), .clr(clr),
    .match_next(mnx[0]), .match(mt[0]), .state(st[0]), .hit_count(hc[0]), .aux_q(aq[0]));
  seq_detect_fsm #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .reset(rst), .en(en), .din(din), .aux(aux), .clr(clr),
    .match_next(mnx[1]), .match(mt[1]), .state(st[1]), .hit_count(hc[1]), .aux_q(aq[1]));
  seq_detect_fsm #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .reset(rst), .en(en), .din(din), .aux(aux), .clr(clr),
    .match_next(mnx[2]), .match(mt[2]), .state(st[2]), .hit_count(hc2), .aux_q(aq[2]));
  seq_detect_fsm #(.LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u3 (
    .clk(clk), .reset(rst), .en(en), .din(din), .aux(aux), .clr(clr),
    .match_next(mnx[3]), .match(mt[3]), .state(st[3]), .hit_count(hc[3]), .aux_q(aq[3]));
  assign hc[2] = {6'b0, hc2};

  typedef struct {
    logic [15:0] pat;
    int          len;
    bit          ovl;
    int          cntw;
  } cfg_t;

  typedef struct {
    logic [31:0] hist;   // accepted bits, newest in bit 0
    int          hlen;
    int          cnt;
    bit          match;
    bit          auxq;
  } mdl_t;

  typedef struct {
    bit r, e, d, a, c;
    int st;
    bit m;
    int cnt;
    bit aq;
    bit mn;
  } vec_t;

  cfg_t cfg [4];
  mdl_t mdl [4];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit suffix_eq(input mdl_t m, input cfg_t c, input int k);
    if (m.hlen < k) return 1'b0;
    for (int i = 0; i < k; i++)
      if (m.hist[k-1-i] != c.pat[c.len-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic mdl_t push(input mdl_t m, input bit d);
    mdl_t r = m;
    r.hist = {m.hist[30:0], d};
    r.hlen = (m.hlen < 32) ? m.hlen + 1 : 32;
    return r;
  endfunction

  function automatic int m_state(input mdl_t m, input cfg_t c);
    int best = 0;
    for (int k = 1; k < c.len; k++)
      if (suffix_eq(m, c, k)) best = k;
    return best;
  endfunction

  function automatic bit m_accept(input mdl_t m, input cfg_t c, input bit e, input bit d);
    if (!e) return 1'b0;
    return suffix_eq(push(m, d), c, c.len);
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input cfg_t c,
                                  input bit r, input bit e, input bit d,
                                  input bit a, input bit cl);
    mdl_t n = m;
    bit acc;
    if (r) begin
      n.hist = '0; n.hlen = 0; n.cnt = 0; n.match = 0; n.auxq = 0;
      return n;
    end
    acc = m_accept(m, c, e, d);
    n.match = acc;
    if (e) n = push(n, d);
    if (acc) begin
      n.auxq = a;
      if (!c.ovl) n.hlen = 0;
    end
    if (cl) n.cnt = 0;
    else if (acc && n.cnt < (1 << c.cntw) - 1) n.cnt++;
    return n;
  endfunction

  task automatic drive(input bit r, input bit e, input bit d, input bit a, input bit c);
    @(negedge clk);
    rst = r; en = e; din = d; aux = a; clr = c;
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("model_mnext[%0d]", i), int'(mnx[i]), int'(m_accept(mdl[i], cfg[i], e, d)));
  endtask

  task automatic edge_chk();
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      mdl[i] = m_step(mdl[i], cfg[i], rst, en, din, aux, clr);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_state[%0d]", i), int'(st[i]), m_state(mdl[i], cfg[i]));
      chk($sformatf("model_match[%0d]", i), int'(mt[i]), int'(mdl[i].match));
      chk($sformatf("model_count[%0d]", i), int'(hc[i]), mdl[i].cnt);
      chk($sformatf("model_auxq[%0d]", i), int'(aq[i]), int'(mdl[i].auxq));
    end
  endtask

  task automatic feed(input bit d);
    drive(1'b0, 1'b1, d, 1'b0, 1'b0);
    edge_chk();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    edge_chk();
  endtask

  vec_t tv[$];

  initial begin
    cfg[0] = '{pat: 16'b1101, len: 4, ovl: 1'b1, cntw: 8};
    cfg[1] = '{pat: 16'b1101, len: 4, ovl: 1'b0, cntw: 8};
    cfg[2] = '{pat: 16'b1101, len: 4, ovl: 1'b1, cntw: 2};
    cfg[3] = '{pat: 16'b1111, len: 4, ovl: 1'b1, cntw: 8};
    for (int i = 0; i < 4; i++) mdl[i] = '{hist: '0, hlen: 0, cnt: 0, match: 0, auxq: 0};

    //            r  e  d  a  c   st m cnt aq mn   (expectations for u0)
    tv.push_back('{1, 0, 0, 0, 0,  0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 0,  3, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 1, 1, 0, 1});
    tv.push_back('{1, 0, 0, 0, 0,  0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 0,  3, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 1, 1, 0, 1});
    tv.push_back('{0, 1, 1, 0, 0,  2, 0, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 0,  3, 0, 1, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 1, 2, 0, 1});
    tv.push_back('{1, 0, 0, 0, 0,  0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 0,  3, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 1, 0,  1, 1, 1, 1, 1});
    tv.push_back('{1, 0, 0, 0, 0,  0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 0, 1, 1, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 0, 1, 0, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 0,  3, 0, 0, 0, 0});
    tv.push_back('{0, 0, 1, 1, 0,  3, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 1, 1, 0, 1});
    tv.push_back('{0, 0, 0, 0, 0,  1, 0, 1, 0, 0});
    tv.push_back('{0, 0, 0, 0, 1,  1, 0, 0, 0, 0});
    tv.push_back('{1, 0, 0, 0, 0,  0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  1, 0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 0,  2, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 0,  3, 0, 0, 0, 0});
    tv.push_back('{1, 1, 1, 1, 0,  0, 0, 0, 0, 1});
    tv.push_back('{0, 1, 1, 0, 0,  1, 0, 0, 0, 0});

    foreach (tv[v]) begin
      drive(tv[v].r, tv[v].e, tv[v].d, tv[v].a, tv[v].c);
      chk($sformatf("vec%0d_mnext", v), int'(mnx[0]), int'(tv[v].mn));
      edge_chk();
      chk($sformatf("vec%0d_state", v), int'(st[0]), tv[v].st);
      chk($sformatf("vec%0d_match", v), int'(mt[0]), int'(tv[v].m));
      chk($sformatf("vec%0d_count", v), int'(hc[0]), tv[v].cnt);
      chk($sformatf("vec%0d_auxq", v), int'(aq[0]), int'(tv[v].aq));
    end

    // Overlap vs. no-overlap on 1101101
    do_reset();
    feed(1); feed(1); feed(0); feed(1); feed(1); feed(0); feed(1);
    chk("ovl_count", int'(hc[0]), 2);
    chk("ovl_match", int'(mt[0]), 1);
    chk("noovl_count", int'(hc[1]), 1);
    chk("noovl_match", int'(mt[1]), 0);

    // Saturation at 3, then clr beats a simultaneous match
    do_reset();
    for (int p = 0; p < 5; p++) begin
      feed(1); feed(1); feed(0); feed(1);
      chk($sformatf("sat_count_%0d", p), int'(hc[2]), (p < 2) ? p + 1 : 3);
      chk($sformatf("sat_match_%0d", p), int'(mt[2]), 1);
    end
    feed(1); feed(1); feed(0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    edge_chk();
    chk("clr_count", int'(hc[2]), 0);
    chk("clr_match", int'(mt[2]), 1);

    // All-ones pattern: back-to-back matches
    do_reset();
    for (int i = 0; i < 6; i++) begin
      feed(1);
      chk($sformatf("ones_match_%0d", i), int'(mt[3]), (i >= 3) ? 1 : 0);
    end
    chk("ones_count", int'(hc[3]), 3);

    // Randomised stream against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
      edge_chk();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
